// File: rtl/chunked_addsub_pkg.sv
// Shared types and constants for the chunked add/sub unit.
// Imported by the top level and the testbench.
package chunked_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunked_addsub_if.sv
// Start/done request bus of the chunked add/sub unit.
// The master issues operands; the slave returns the result and flags.
interface chunked_addsub_if #(parameter int WIDTH = 32);

   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output start, mode, a, b,
      input  busy, done, s, cout, ovf, zero
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, s, cout, ovf, zero
   );

endinterface

// File: rtl/chunked_addsub_rca_n.sv
// Combinational N-bit ripple-carry adder.
// Also exposes the carry into the MSB so the caller can form signed overflow.
module rca_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   output logic [N-1:0] s_o,
   output logic         cout_o,
   output logic         c_msb_in_o
);

   logic [N-1:0] sum;
   logic         carry;
   logic         cMsb;

   always_comb begin
      sum   = '0;
      carry = cin_i;
      cMsb  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) cMsb = carry;
         sum[i] = a_i[i] ^ b_i[i] ^ carry;
         carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
   end

   assign s_o        = sum;
   assign cout_o     = carry;
   assign c_msb_in_o = cMsb;

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock
// through a single ripple-carry stage, with a start/busy/done handshake and status flags.
module chunked_addsub
   import chunked_addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   chunked_addsub_if.slave bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [CHUNK-1:0] chunkSum;
   logic             chunkCout;
   logic             chunkMsbIn;
   logic [WIDTH-1:0] accNext;

   rca_n #(.N(CHUNK)) uRca (
      .a_i        (opA_q[CHUNK-1:0]),
      .b_i        (opB_q[CHUNK-1:0]),
      .cin_i      (carry_q),
      .s_o        (chunkSum),
      .cout_o     (chunkCout),
      .c_msb_in_o (chunkMsbIn)
   );

   // Each new chunk sum enters at the MSB end, so after NCHUNK steps the low chunk sits at bit 0.
   assign accNext = WIDTH'({chunkSum, acc_q} >> CHUNK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      acc_d   = acc_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with the mode bit.
            if (bus.start) begin
               state_d = ST_RUN;
               opA_d   = bus.a;
               opB_d   = bus.b ^ {WIDTH{bus.mode}};
               carry_d = (bus.mode == MODE_SUB);
               cnt_d   = '0;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            opA_d   = opA_q >> CHUNK;
            opB_d   = opB_q >> CHUNK;
            acc_d   = accNext;
            carry_d = chunkCout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
               s_d     = accNext;
               cout_d  = chunkCout;
               ovf_d   = chunkMsbIn ^ chunkCout;
               zero_d  = (accNext == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);
   assign bus.s    = s_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub at 32/8, 8/1 and 16/16 widths/chunks.
// Expected results are queued when an operation is issued and popped when done is seen.
module tb_chunked_addsub;
   import chunked_addsub_pkg::*;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   chunked_addsub_if #(.WIDTH(32)) bus0 ();
   chunked_addsub_if #(.WIDTH(8))  bus1 ();
   chunked_addsub_if #(.WIDTH(16)) bus2 ();

   chunked_addsub #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   chunked_addsub #(.WIDTH(8),  .CHUNK(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   res_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Behavioural reference: plain modular arithmetic, overflow from operand/result signs.
   function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic mode);
      res_t r;
      longint unsigned m, aa, bb, full;
      m    = (64'd1 << w) - 1;
      aa   = {32'd0, a} & m;
      bb   = (mode ? ~{32'd0, b} : {32'd0, b}) & m;
      full = aa + bb + {63'd0, mode};
      r.s    = 32'(full & m);
      r.cout = full[w];
      r.ovf  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
      r.zero = (r.s == 32'd0);
      return r;
   endfunction

   // Called at a negedge: presents one request for a single cycle on bus0.
   task automatic drive0(logic [31:0] a, logic [31:0] b, logic mode, res_t exp, bit push);
      bus0.start = 1'b1;
      bus0.a     = a;
      bus0.b     = b;
      bus0.mode  = mode;
      if (push) sb.push_back(exp);
      @(negedge clk);
      bus0.start = 1'b0;
   endtask

   task automatic waitDone0(output int cyc, output int busyCnt);
      cyc     = 0;
      busyCnt = 0;
      while (bus0.done !== 1'b1 && cyc < 64) begin
         if (bus0.busy === 1'b1) busyCnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      logic [37:0] obs;
      #2 rst_n = 1'b0;
      #1;
      obs = {bus0.busy, bus0.done, bus0.s, bus0.cout, bus0.ovf, bus0.zero};
      vectors++;
      if (obs !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, 38'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] ta[5], tb[5];
      logic        tm[5];
      res_t        te[5];
      res_t        exp, obs;
      int          cyc, busyCnt;
      ta[0] = 32'h000000FF; tb[0] = 32'h00000001; tm[0] = MODE_ADD; te[0] = '{32'h00000100, 1'b0, 1'b0, 1'b0};
      ta[1] = 32'd5;        tb[1] = 32'd7;        tm[1] = MODE_SUB; te[1] = '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      ta[2] = 32'd7;        tb[2] = 32'd7;        tm[2] = MODE_SUB; te[2] = '{32'h00000000, 1'b1, 1'b0, 1'b1};
      ta[3] = 32'h7FFFFFFF; tb[3] = 32'h00000001; tm[3] = MODE_ADD; te[3] = '{32'h80000000, 1'b0, 1'b1, 1'b0};
      ta[4] = 32'h80000000; tb[4] = 32'h00000001; tm[4] = MODE_SUB; te[4] = '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive0(ta[i], tb[i], tm[i], te[i], 1'b1);
         waitDone0(cyc, busyCnt);
         vectors++;
         if (cyc != 4 || busyCnt != 4) begin
            miscompares++;
            $display("[TB] FAIL directed_latency[%0d]: got done@%0d busy=%0d expected 4/4", i, cyc, busyCnt);
         end
         exp = sb.pop_front();
         obs = '{bus0.s, bus0.cout, bus0.ovf, bus0.zero};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL directed_result[%0d]: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                     i, obs.s, obs.cout, obs.ovf, obs.zero, exp.s, exp.cout, exp.ovf, exp.zero);
         end
         @(negedge clk);
         vectors++;
         if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.s !== te[i].s) begin
            miscompares++;
            $display("[TB] FAIL directed_hold[%0d]: got done=%b busy=%b s=%h expected 0/0/%h",
                     i, bus0.done, bus0.busy, bus0.s, te[i].s);
         end
      end
   endtask

   task automatic test_back_to_back();
      res_t exp, obs;
      int   cyc, busyCnt;
      drive0(32'd10, 32'd20, MODE_ADD, '{32'd30, 1'b0, 1'b0, 1'b0}, 1'b1);
      @(negedge clk);
      bus0.start = 1'b1;
      bus0.a     = 32'hDEADBEEF;
      bus0.b     = 32'h12345678;
      bus0.mode  = MODE_SUB;
      @(negedge clk);
      bus0.start = 1'b0;
      vectors++;
      if (bus0.busy !== 1'b1 || bus0.s !== 32'h7FFFFFFF) begin
         miscompares++;
         $display("[TB] FAIL busy_hold: got busy=%b s=%h expected 1/7fffffff", bus0.busy, bus0.s);
      end
      waitDone0(cyc, busyCnt);
      vectors++;
      if (cyc + 2 != 4) begin
         miscompares++;
         $display("[TB] FAIL ignored_start_latency: got %0d expected 4", cyc + 2);
      end
      exp = sb.pop_front();
      obs = '{bus0.s, bus0.cout, bus0.ovf, bus0.zero};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL ignored_start_result: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                  obs.s, obs.cout, obs.ovf, obs.zero, exp.s, exp.cout, exp.ovf, exp.zero);
      end
      drive0(32'd100, 32'd1, MODE_SUB, '{32'd99, 1'b1, 1'b0, 1'b0}, 1'b1);
      vectors++;
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_accept: got done=%b busy=%b expected 0/1", bus0.done, bus0.busy);
      end
      waitDone0(cyc, busyCnt);
      vectors++;
      if (cyc != 4) begin
         miscompares++;
         $display("[TB] FAIL b2b_latency: got %0d expected 4", cyc);
      end
      exp = sb.pop_front();
      obs = '{bus0.s, bus0.cout, bus0.ovf, bus0.zero};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL b2b_result: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                  obs.s, obs.cout, obs.ovf, obs.zero, exp.s, exp.cout, exp.ovf, exp.zero);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      logic [37:0] obs0;
      res_t        exp, obs;
      int          cyc, busyCnt;
      bit          sawDone;
      drive0(32'h00012345, 32'd1, MODE_ADD, '{32'd0, 1'b0, 1'b0, 1'b0}, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      obs0 = {bus0.busy, bus0.done, bus0.s, bus0.cout, bus0.ovf, bus0.zero};
      vectors++;
      if (obs0 !== 38'd0) begin
         miscompares++;
         $display("[TB] FAIL midrun_reset: got %h expected %h", obs0, 38'd0);
      end
      sawDone = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (bus0.done === 1'b1) sawDone = 1'b1;
      end
      vectors++;
      if (sawDone) begin
         miscompares++;
         $display("[TB] FAIL midrun_no_done: got done pulse expected none");
      end
      drive0(32'd1, 32'd1, MODE_ADD, '{32'd2, 1'b0, 1'b0, 1'b0}, 1'b1);
      waitDone0(cyc, busyCnt);
      vectors++;
      if (cyc != 4) begin
         miscompares++;
         $display("[TB] FAIL post_reset_latency: got %0d expected 4", cyc);
      end
      exp = sb.pop_front();
      obs = '{bus0.s, bus0.cout, bus0.ovf, bus0.zero};
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL post_reset_result: got s=%h expected s=%h", obs.s, exp.s);
      end
      @(negedge clk);
   endtask

   task automatic test_sweep_w8c1();
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] av, bv;
         logic       md;
         int         cyc;
         res_t       exp, obs;
         av = 8'($urandom);
         bv = 8'($urandom);
         md = 1'($urandom);
         if (i % 16 == 0) av = 8'h80;
         if (i % 16 == 1) bv = 8'h7F;
         if (i % 16 == 2) bv = av;
         bus1.a = av; bus1.b = bv; bus1.mode = md; bus1.start = 1'b1;
         sb.push_back(model(8, 32'(av), 32'(bv), md));
         @(negedge clk);
         bus1.start = 1'b0;
         cyc = 0;
         while (bus1.done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
         end
         vectors++;
         if (cyc != 8) begin
            miscompares++;
            $display("[TB] FAIL w8c1_latency[%0d]: got %0d expected 8", i, cyc);
         end
         exp = sb.pop_front();
         obs = '{32'(bus1.s), bus1.cout, bus1.ovf, bus1.zero};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL w8c1_result[%0d] %h %s %h: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                     i, av, md ? "-" : "+", bv, obs.s, obs.cout, obs.ovf, obs.zero,
                     exp.s, exp.cout, exp.ovf, exp.zero);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_sweep_w16c16();
      for (int i = 0; i < 1000; i++) begin
         logic [15:0] av, bv;
         logic        md;
         int          cyc;
         res_t        exp, obs;
         av = 16'($urandom);
         bv = 16'($urandom);
         md = 1'($urandom);
         if (i % 16 == 0) av = 16'h8000;
         if (i % 16 == 1) bv = 16'hFFFF;
         if (i % 16 == 2) bv = av;
         bus2.a = av; bus2.b = bv; bus2.mode = md; bus2.start = 1'b1;
         sb.push_back(model(16, 32'(av), 32'(bv), md));
         @(negedge clk);
         bus2.start = 1'b0;
         cyc = 0;
         while (bus2.done !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
         end
         vectors++;
         if (cyc != 1) begin
            miscompares++;
            $display("[TB] FAIL w16c16_latency[%0d]: got %0d expected 1", i, cyc);
         end
         exp = sb.pop_front();
         obs = '{32'(bus2.s), bus2.cout, bus2.ovf, bus2.zero};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL w16c16_result[%0d] %h %s %h: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                     i, av, md ? "-" : "+", bv, obs.s, obs.cout, obs.ovf, obs.zero,
                     exp.s, exp.cout, exp.ovf, exp.zero);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      bus0.start = 1'b0; bus0.mode = 1'b0; bus0.a = '0; bus0.b = '0;
      bus1.start = 1'b0; bus1.mode = 1'b0; bus1.a = '0; bus1.b = '0;
      bus2.start = 1'b0; bus2.mode = 1'b0; bus2.a = '0; bus2.b = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midrun();
      test_sweep_w8c1();
      test_sweep_w16c16();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
